rgb_pwm_sequencer: RTL and testbench

//   Parametrised N-channel PWM LED sequencer driving SB_RGBA_DRV PWM inputs (RGBxPWM).

---
 rtl/rgb_pwm_sequencer_pkg.sv | 21 ++
 rtl/rgb_pwm_sequencer_if.sv | 25 ++
 rtl/rgb_pwm_channel.sv | 126 ++++++++++++
 rtl/rgb_pwm_sequencer.sv | 77 +++++++
 tb/tb_rgb_pwm_sequencer.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/rgb_pwm_sequencer_pkg.sv
// rgb_pwm_sequencer shared types: channel modes and breathe FSM states.
// Optional feature macro used by this block: RGB_PWM_BREATHE_EN.
package rgb_pwm_sequencer_pkg;

    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_STATIC  = 2'd1,
        MODE_BLINK   = 2'd2,
        MODE_BREATHE = 2'd3
    } mode_t;

    typedef enum logic {
        BR_UP   = 1'b0,
        BR_DOWN = 1'b1
    } br_state_t;

    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rgb_pwm_sequencer_if.sv
// rgb_pwm_sequencer config write channel (valid/ready handshake).
// Master drives the write, slave (the sequencer) returns ready.
interface rgb_pwm_sequencer_if #(
    parameter int CH_W  = 2,
    parameter int PWM_W = 8
);
    import rgb_pwm_sequencer_pkg::*;

    logic             cfg_valid;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_ch;
    logic [PWM_W-1:0] cfg_duty;
    mode_t            cfg_mode;

    modport master (
        output cfg_valid, cfg_ch, cfg_duty, cfg_mode,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_ch, cfg_duty, cfg_mode,
        output cfg_ready
    );

endinterface

// File: rtl/rgb_pwm_channel.sv
// One PWM channel: shadow/active config, breathe FSM, compare and output flop.
// Breathe logic is built only when RGB_PWM_BREATHE_EN is defined.
module rgb_pwm_channel
    import rgb_pwm_sequencer_pkg::*;
#(
    parameter int PWM_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic [PWM_W-1:0] i_cnt,
    input  logic             i_wrap,
    input  logic             i_blink,
    input  logic             i_wr,
    input  logic [PWM_W-1:0] i_duty,
    input  mode_t            i_mode,
    output logic             o_pending,
    output logic             o_pwm
);

    logic [PWM_W-1:0] r_sh_duty;
    logic [PWM_W-1:0] r_duty;
    logic [PWM_W-1:0] w_eff;
    mode_t            r_sh_mode;
    mode_t            r_mode;
    mode_t            w_mode_in;
    logic             r_pending;
    logic             w_commit;

`ifdef RGB_PWM_BREATHE_EN
    assign w_mode_in = i_mode;
`else
    assign w_mode_in = (i_mode == MODE_BREATHE) ? MODE_STATIC : i_mode;
`endif

    assign w_commit  = i_wrap && r_pending;
    assign o_pending = r_pending;

    // Capture on accept; active copy changes only at a period wrap
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_sh_duty <= '0;
            r_sh_mode <= MODE_OFF;
            r_duty    <= '0;
            r_mode    <= MODE_OFF;
            r_pending <= 1'b0;
        end else begin
            if (w_commit) begin
                r_duty    <= r_sh_duty;
                r_mode    <= r_sh_mode;
                r_pending <= 1'b0;
            end
            if (i_wr) begin
                r_sh_duty <= i_duty;
                r_sh_mode <= w_mode_in;
                r_pending <= 1'b1;
            end
        end
    end

`ifdef RGB_PWM_BREATHE_EN
    logic [PWM_W-1:0] r_lvl;
    logic [PWM_W-1:0] w_duty_nxt;
    br_state_t        r_st;
    mode_t            w_mode_nxt;

    assign w_duty_nxt = w_commit ? r_sh_duty : r_duty;
    assign w_mode_nxt = w_commit ? r_sh_mode : r_mode;

    // Breathe ramp; turning points step straight back so peaks last one period
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_lvl <= '0;
            r_st  <= BR_UP;
        end else if (w_commit && r_sh_mode == MODE_BREATHE
                     && r_mode != MODE_BREATHE) begin
            r_lvl <= '0;
            r_st  <= BR_UP;
        end else if (w_commit && r_sh_mode == MODE_BREATHE
                     && r_sh_duty < r_lvl) begin
            r_lvl <= r_sh_duty;
            r_st  <= BR_DOWN;
        end else if (i_wrap && w_mode_nxt == MODE_BREATHE) begin
            unique case (r_st)
                BR_UP: begin
                    if (r_lvl == w_duty_nxt) begin
                        r_st  <= BR_DOWN;
                        r_lvl <= (r_lvl == '0) ? r_lvl : r_lvl - 1'b1;
                    end else begin
                        r_lvl <= r_lvl + 1'b1;
                    end
                end
                BR_DOWN: begin
                    if (r_lvl == '0) begin
                        r_st  <= BR_UP;
                        r_lvl <= (w_duty_nxt == '0) ? r_lvl : r_lvl + 1'b1;
                    end else begin
                        r_lvl <= r_lvl - 1'b1;
                    end
                end
            endcase
        end
    end
`endif

    // Effective duty per mode
    always_comb begin
        w_eff = '0;
        unique case (r_mode)
            MODE_OFF:     w_eff = '0;
            MODE_STATIC:  w_eff = r_duty;
            MODE_BLINK:   w_eff = i_blink ? '0 : r_duty;
`ifdef RGB_PWM_BREATHE_EN
            MODE_BREATHE: w_eff = r_lvl;
`else
            MODE_BREATHE: w_eff = r_duty;
`endif
        endcase
    end

    // Registered compare output
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) o_pwm <= 1'b0;
        else         o_pwm <= (i_cnt < w_eff);
    end

endmodule

// File: rtl/rgb_pwm_sequencer.sv
// N-channel PWM LED sequencer for SB_RGBA_DRV: prescaler, period/blink counters, cfg.
// Define RGB_PWM_BREATHE_EN to build BREATHE mode; otherwise mode 3 acts as STATIC.
module rgb_pwm_sequencer
    import rgb_pwm_sequencer_pkg::*;
#(
    parameter int NUM_CH     = 3,
    parameter int PWM_W      = 8,
    parameter int PRESCALE_W = 16,
    parameter int BLINK_W    = 6
) (
    input  logic                  int_osc,
    input  logic                  rstn,
    input  logic [PRESCALE_W-1:0] prescale,
    rgb_pwm_sequencer_if.slave    cfg,
    output logic [NUM_CH-1:0]     pwm_out,
    output logic                  period_strobe
);

    localparam int CH_W = ch_w(NUM_CH);
    localparam int CH_N = 1 << CH_W;

    logic [PRESCALE_W-1:0] r_pre_cnt;
    logic [PWM_W-1:0]      r_cnt;
    logic [BLINK_W-1:0]    r_blink;
    logic                  w_tick;
    logic                  w_wrap;
    logic [NUM_CH-1:0]     w_pending;
    logic [NUM_CH-1:0]     w_wr;
    logic [CH_N-1:0]       w_pend_ext;

    assign w_tick     = (r_pre_cnt == prescale);
    assign w_wrap     = w_tick && (r_cnt == {PWM_W{1'b1}});
    // Unused channel slots read as not pending, so they always accept
    assign w_pend_ext = CH_N'(w_pending);
    assign cfg.cfg_ready = ~w_pend_ext[cfg.cfg_ch];

    // Prescaler; also restarts at once if prescale drops below the count
    always_ff @(posedge int_osc or negedge rstn) begin
        if (!rstn)                     r_pre_cnt <= '0;
        else if (r_pre_cnt >= prescale) r_pre_cnt <= '0;
        else                            r_pre_cnt <= r_pre_cnt + PRESCALE_W'(1);
    end

    // PWM period counter, blink counter and period strobe
    always_ff @(posedge int_osc or negedge rstn) begin
        if (!rstn) begin
            r_cnt         <= '0;
            r_blink       <= '0;
            period_strobe <= 1'b0;
        end else begin
            period_strobe <= w_wrap;
            if (w_tick) r_cnt <= r_cnt + PWM_W'(1);
            if (w_wrap) r_blink <= r_blink + BLINK_W'(1);
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        assign w_wr[c] = cfg.cfg_valid && cfg.cfg_ready
                         && (cfg.cfg_ch == CH_W'(c));

        rgb_pwm_channel #(
            .PWM_W (PWM_W)
        ) u_ch (
            .i_clk     (int_osc),
            .i_rstn    (rstn),
            .i_cnt     (r_cnt),
            .i_wrap    (w_wrap),
            .i_blink   (r_blink[BLINK_W-1]),
            .i_wr      (w_wr[c]),
            .i_duty    (cfg.cfg_duty),
            .i_mode    (cfg.cfg_mode),
            .o_pending (w_pending[c]),
            .o_pwm     (pwm_out[c])
        );
    end

endmodule

// File: tb/tb_rgb_pwm_sequencer.sv
// Directed bench for rgb_pwm_sequencer (3 ch, PWM_W=8, BLINK_W=2).
// Breathe expectations follow RGB_PWM_BREATHE_EN.
module tb_rgb_pwm_sequencer;
    import rgb_pwm_sequencer_pkg::*;

    localparam int NUM_CH     = 3;
    localparam int PWM_W      = 8;
    localparam int PRESCALE_W = 16;
    localparam int BLINK_W    = 2;
    localparam int CH_W       = 2;

    logic                  clk = 1'b0;
    logic                  rstn = 1'b0;
    logic [PRESCALE_W-1:0] prescale = '0;
    logic [NUM_CH-1:0]     pwm_out;
    logic                  period_strobe;

    int n_vec = 0;
    int n_err = 0;
    int h0, h1, h2;
    int t3_exp[4] = '{0, 0, 255, 255};
`ifdef RGB_PWM_BREATHE_EN
    int t4_exp[8] = '{0, 1, 2, 3, 2, 1, 0, 1};
`else
    int t4_exp[8] = '{3, 3, 3, 3, 3, 3, 3, 3};
`endif

    rgb_pwm_sequencer_if #(.CH_W(CH_W), .PWM_W(PWM_W)) bus ();

    rgb_pwm_sequencer #(
        .NUM_CH     (NUM_CH),
        .PWM_W      (PWM_W),
        .PRESCALE_W (PRESCALE_W),
        .BLINK_W    (BLINK_W)
    ) dut (
        .int_osc       (clk),
        .rstn          (rstn),
        .prescale      (prescale),
        .cfg           (bus.slave),
        .pwm_out       (pwm_out),
        .period_strobe (period_strobe)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cfg_write(input int ch, input int duty, input mode_t m);
        bus.cfg_ch    = CH_W'(ch);
        bus.cfg_duty  = PWM_W'(duty);
        bus.cfg_mode  = m;
        bus.cfg_valid = 1'b1;
        @(posedge clk);
        #1 bus.cfg_valid = 1'b0;
    endtask

    // Count high cycles up to and including the next strobe cycle
    task automatic sync(output int c0, output int c1, output int c2);
        int n = 0;
        c0 = 0; c1 = 0; c2 = 0;
        do begin
            @(negedge clk);
            c0 += int'(pwm_out[0]);
            c1 += int'(pwm_out[1]);
            c2 += int'(pwm_out[2]);
            n++;
        end while (!period_strobe && n < 5000);
        if (!period_strobe) check("sync_timeout", 0, 1);
    endtask

    // Count high cycles over one full period that follows a strobe cycle
    task automatic count_period(output int c0, output int c1, output int c2);
        int len = 256 * (int'(prescale) + 1);
        c0 = 0; c1 = 0; c2 = 0;
        repeat (len) begin
            @(negedge clk);
            c0 += int'(pwm_out[0]);
            c1 += int'(pwm_out[1]);
            c2 += int'(pwm_out[2]);
        end
        check("strobe_spacing", int'(period_strobe), 1);
    endtask

    initial begin
        bus.cfg_valid = 1'b0;
        bus.cfg_ch    = '0;
        bus.cfg_duty  = '0;
        bus.cfg_mode  = MODE_OFF;

        repeat (3) @(negedge clk);
        check("rst_pwm", int'(pwm_out), 0);
        check("rst_strobe", int'(period_strobe), 0);
        check("rst_ready", int'(bus.cfg_ready), 1);
        rstn = 1'b1;

        cfg_write(0, 64, MODE_STATIC);
        sync(h0, h1, h2);
        count_period(h0, h1, h2);
        check("t1_ch0_p1", h0, 64);
        check("t1_ch1_off", h1, 0);
        count_period(h0, h1, h2);
        check("t1_ch0_p2", h0, 64);
        check("t1_ch2_off", h2, 0);

        repeat (100) @(negedge clk);
        bus.cfg_ch = 2'd1;
        #1 check("t2_ready_free", int'(bus.cfg_ready), 1);
        cfg_write(1, 200, MODE_STATIC);
        repeat (20) @(negedge clk);
        bus.cfg_ch    = 2'd1;
        bus.cfg_duty  = 8'd10;
        bus.cfg_mode  = MODE_STATIC;
        bus.cfg_valid = 1'b1;
        #1 check("t2_ready_busy", int'(bus.cfg_ready), 0);
        @(posedge clk);
        #1 bus.cfg_valid = 1'b0;
        bus.cfg_ch = 2'd0;
        #1 check("t2_ready_ch0", int'(bus.cfg_ready), 1);
        bus.cfg_ch = 2'd3;
        #1 check("t2_ready_oob", int'(bus.cfg_ready), 1);
        sync(h0, h1, h2);
        check("t2_no_runt", h1, 0);
        count_period(h0, h1, h2);
        check("t2_ch1_new", h1, 200);
        check("t2_ch0_keep", h0, 64);

        cfg_write(2, 255, MODE_BLINK);
        sync(h0, h1, h2);
        check("t3_pre", h2, 0);
        for (int i = 0; i < 4; i++) begin
            count_period(h0, h1, h2);
            check($sformatf("t3_blink%0d", i), h2, t3_exp[i]);
        end

        cfg_write(0, 3, MODE_BREATHE);
        sync(h0, h1, h2);
        for (int i = 0; i < 8; i++) begin
            count_period(h0, h1, h2);
            check($sformatf("t4_breathe%0d", i), h0, t4_exp[i]);
        end

        cfg_write(0, 0, MODE_STATIC);
        @(negedge clk);
        cfg_write(1, 255, MODE_STATIC);
        sync(h0, h1, h2);
        prescale = 16'd3;
        for (int i = 0; i < 2; i++) begin
            count_period(h0, h1, h2);
            check($sformatf("t5_duty0_%0d", i), h0, 0);
            check($sformatf("t5_duty255_%0d", i), h1, 1020);
        end
        repeat (2) @(negedge clk);
        prescale = 16'd0;
        sync(h0, h1, h2);
        count_period(h0, h1, h2);
        check("t5_lowered", h1, 255);

        repeat (50) @(negedge clk);
        cfg_write(2, 100, MODE_STATIC);
        bus.cfg_ch = 2'd2;
        #1 check("t6_pending", int'(bus.cfg_ready), 0);
        repeat (10) @(negedge clk);
        check("t6_pre_pwm1", int'(pwm_out[1]), 1);
        rstn = 1'b0;
        #1 check("t6_async_pwm", int'(pwm_out), 0);
        check("t6_async_strobe", int'(period_strobe), 0);
        @(negedge clk);
        rstn = 1'b1;
        bus.cfg_ch = 2'd2;
        #1 check("t6_ready", int'(bus.cfg_ready), 1);
        sync(h0, h1, h2);
        count_period(h0, h1, h2);
        check("t6_ch0_off", h0, 0);
        check("t6_ch1_off", h1, 0);
        check("t6_ch2_off", h2, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
